// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage: valid/ready handshake, combinational register-file read,
// registered decoded bundle with illegal-instruction detection and a decoded-instruction counter.
module decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [XLEN-1:0]  i_PC_XLEN,
    input  logic [31:0]      i_Inst_32,
    output logic [4:0]       o_GRFReadAddr1_5,
    output logic [4:0]       o_GRFReadAddr2_5,
    input  logic [XLEN-1:0]  i_GRFReadData1_XLEN,
    input  logic [XLEN-1:0]  i_GRFReadData2_XLEN,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [XLEN-1:0]  o_PC_XLEN,
    output logic [XLEN-1:0]  o_Rs1Data_XLEN,
    output logic [XLEN-1:0]  o_Rs2Data_XLEN,
    output logic [XLEN-1:0]  o_Imm_XLEN,
    output logic [4:0]       o_Rd_5,
    output logic             o_RdWen,
    output logic [3:0]       o_AluOp_4,
    output logic [2:0]       o_Class_3,
    output logic             o_Word,
    output logic             o_Illegal,
    output logic [CNT_W-1:0] o_DecCnt_CNTW
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [2:0] CLS_ALU = 3'd0, CLS_LOAD = 3'd1, CLS_STORE = 3'd2, CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JAL = 3'd4, CLS_JALR = 3'd5, CLS_SYSTEM = 3'd6, CLS_FENCE = 3'd7;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_Inst_32[6:0];
    assign f3     = i_Inst_32[14:12];
    assign f7     = i_Inst_32[31:25];
    assign rd     = i_Inst_32[11:7];

    assign imm_i = {{(XLEN-11){i_Inst_32[31]}}, i_Inst_32[30:20]};
    assign imm_s = {{(XLEN-11){i_Inst_32[31]}}, i_Inst_32[30:25], i_Inst_32[11:7]};
    assign imm_b = {{(XLEN-12){i_Inst_32[31]}}, i_Inst_32[7], i_Inst_32[30:25], i_Inst_32[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){i_Inst_32[31]}}, i_Inst_32[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){i_Inst_32[31]}}, i_Inst_32[19:12], i_Inst_32[20], i_Inst_32[30:21], 1'b0};

    assign o_GRFReadAddr1_5 = i_Inst_32[19:15];
    assign o_GRFReadAddr2_5 = i_Inst_32[24:20];

    logic [XLEN-1:0] imm_next, rs1_next, rs2_next;
    logic [3:0]      alu_next;
    logic [2:0]      class_next;
    logic            wen_raw, rd_wen_next, word_next, illegal_next;

    assign rs1_next = (o_GRFReadAddr1_5 == 5'd0) ? '0 : i_GRFReadData1_XLEN;
    assign rs2_next = (o_GRFReadAddr2_5 == 5'd0) ? '0 : i_GRFReadData2_XLEN;

    always_comb begin
        imm_next     = '0;
        alu_next     = ALU_ADD;
        class_next   = CLS_ALU;
        wen_raw      = 1'b0;
        word_next    = 1'b0;
        illegal_next = 1'b0;
        rd_wen_next  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_next = imm_u;
                alu_next = ALU_PASSB;
                wen_raw  = 1'b1;
            end
            OPC_AUIPC: begin
                imm_next = imm_u;
                wen_raw  = 1'b1;
            end
            OPC_JAL: begin
                imm_next   = imm_j;
                class_next = CLS_JAL;
                wen_raw    = 1'b1;
            end
            OPC_JALR: begin
                imm_next     = imm_i;
                class_next   = CLS_JALR;
                wen_raw      = 1'b1;
                illegal_next = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm_next   = imm_b;
                class_next = CLS_BRANCH;
                case (f3)
                    3'b000, 3'b001: alu_next = ALU_SUB;
                    3'b100, 3'b101: alu_next = ALU_SLT;
                    3'b110, 3'b111: alu_next = ALU_SLTU;
                    default:        illegal_next = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm_next     = imm_i;
                class_next   = CLS_LOAD;
                wen_raw      = 1'b1;
                illegal_next = (f3 == 3'b111) || (!IS64 && (f3 == 3'b110 || f3 == 3'b011));
            end
            OPC_STORE: begin
                imm_next     = imm_s;
                class_next   = CLS_STORE;
                illegal_next = (f3 > 3'b011) || (!IS64 && f3 == 3'b011);
            end
            OPC_OPIMM: begin
                imm_next = imm_i;
                wen_raw  = 1'b1;
                alu_next = alu_of(f3, 1'b0);
                // Shift immediates carry a funct6 above shamt; only SRAI may set bit 30.
                if (f3 == 3'b001) begin
                    illegal_next = (i_Inst_32[31:26] != 6'b000000);
                end else if (f3 == 3'b101) begin
                    if (i_Inst_32[31:26] == 6'b010000)
                        alu_next = ALU_SRA;
                    else if (i_Inst_32[31:26] != 6'b000000)
                        illegal_next = 1'b1;
                end
                if ((f3 == 3'b001 || f3 == 3'b101) && !IS64 && i_Inst_32[25])
                    illegal_next = 1'b1;
            end
            OPC_OP: begin
                wen_raw      = 1'b1;
                alu_next     = alu_of(f3, f7[5]);
                illegal_next = !((f7 == 7'b0000000) ||
                                 (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OPIMMW: begin
                imm_next  = imm_i;
                wen_raw   = 1'b1;
                word_next = 1'b1;
                alu_next  = alu_of(f3, f7[5] & (f3 == 3'b101));
                case (f3)
                    3'b000:  illegal_next = 1'b0;
                    3'b001:  illegal_next = (f7 != 7'b0000000);
                    3'b101:  illegal_next = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                    default: illegal_next = 1'b1;
                endcase
                if (!IS64) illegal_next = 1'b1;
            end
            OPC_OPW: begin
                wen_raw   = 1'b1;
                word_next = 1'b1;
                alu_next  = alu_of(f3, f7[5]);
                illegal_next = !(((f7 == 7'b0000000) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                                 ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101)));
                if (!IS64) illegal_next = 1'b1;
            end
            OPC_FENCE: begin
                class_next = CLS_FENCE;
            end
            OPC_SYSTEM: begin
                class_next   = CLS_SYSTEM;
                illegal_next = (i_Inst_32 != 32'h0000_0073) && (i_Inst_32 != 32'h0010_0073);
            end
            default: illegal_next = 1'b1;
        endcase
        if (i_Inst_32[1:0] != 2'b11)
            illegal_next = 1'b1;
        // Illegal instructions travel as side-effect-free SYSTEM bundles so execute can trap.
        if (illegal_next) begin
            class_next = CLS_SYSTEM;
            wen_raw    = 1'b0;
            word_next  = 1'b0;
        end
        rd_wen_next = wen_raw && (rd != 5'd0);
    end

    logic             valid_reg, rd_wen_reg, word_reg, illegal_reg;
    logic [XLEN-1:0]  pc_reg, rs1_reg, rs2_reg, imm_reg;
    logic [4:0]       rd_reg;
    logic [3:0]       alu_reg;
    logic [2:0]       class_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;

    assign o_Ready = ~valid_reg | i_Ready;
    assign accept  = i_Valid & o_Ready & ~i_Flush;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            valid_reg   <= 1'b0;
            pc_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            imm_reg     <= '0;
            rd_reg      <= '0;
            rd_wen_reg  <= 1'b0;
            alu_reg     <= '0;
            class_reg   <= '0;
            word_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else if (i_Flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            pc_reg      <= i_PC_XLEN;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            imm_reg     <= imm_next;
            rd_reg      <= rd;
            rd_wen_reg  <= rd_wen_next;
            alu_reg     <= alu_next;
            class_reg   <= class_next;
            word_reg    <= word_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_reg + CNT_W'(1);
        end else if (i_Ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign o_Valid        = valid_reg;
    assign o_PC_XLEN      = pc_reg;
    assign o_Rs1Data_XLEN = rs1_reg;
    assign o_Rs2Data_XLEN = rs2_reg;
    assign o_Imm_XLEN     = imm_reg;
    assign o_Rd_5         = rd_reg;
    assign o_RdWen        = rd_wen_reg;
    assign o_AluOp_4      = alu_reg;
    assign o_Class_3      = class_reg;
    assign o_Word         = word_reg;
    assign o_Illegal      = illegal_reg;
    assign o_DecCnt_CNTW  = cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV64 instance and an RV32 instance (4-bit counter) share one
// stimulus stream and are compared every cycle against a behavioural decode model.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, ds_ready;
    logic [31:0] inst;
    logic [63:0] pc, d1, d2;

    logic        rdy64, v64, wen64, word64, ill64;
    logic [4:0]  a1_64, a2_64, rd64;
    logic [63:0] pc64, rs1_64, rs2_64, imm64;
    logic [3:0]  alu64;
    logic [2:0]  cls64;
    logic [31:0] cnt64;

    logic        rdy32, v32, wen32, word32, ill32;
    logic [4:0]  a1_32, a2_32, rd32;
    logic [31:0] pc32, rs1_32, rs2_32, imm32;
    logic [3:0]  alu32;
    logic [2:0]  cls32;
    logic [3:0]  cnt32;

    decode_stage #(.XLEN(64), .CNT_W(32)) dut64 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Flush(flush), .i_Valid(in_valid), .o_Ready(rdy64),
        .i_PC_XLEN(pc), .i_Inst_32(inst), .o_GRFReadAddr1_5(a1_64), .o_GRFReadAddr2_5(a2_64),
        .i_GRFReadData1_XLEN(d1), .i_GRFReadData2_XLEN(d2), .o_Valid(v64), .i_Ready(ds_ready),
        .o_PC_XLEN(pc64), .o_Rs1Data_XLEN(rs1_64), .o_Rs2Data_XLEN(rs2_64), .o_Imm_XLEN(imm64),
        .o_Rd_5(rd64), .o_RdWen(wen64), .o_AluOp_4(alu64), .o_Class_3(cls64), .o_Word(word64),
        .o_Illegal(ill64), .o_DecCnt_CNTW(cnt64)
    );

    decode_stage #(.XLEN(32), .CNT_W(4)) dut32 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Flush(flush), .i_Valid(in_valid), .o_Ready(rdy32),
        .i_PC_XLEN(pc[31:0]), .i_Inst_32(inst), .o_GRFReadAddr1_5(a1_32), .o_GRFReadAddr2_5(a2_32),
        .i_GRFReadData1_XLEN(d1[31:0]), .i_GRFReadData2_XLEN(d2[31:0]), .o_Valid(v32), .i_Ready(ds_ready),
        .o_PC_XLEN(pc32), .o_Rs1Data_XLEN(rs1_32), .o_Rs2Data_XLEN(rs2_32), .o_Imm_XLEN(imm32),
        .o_Rd_5(rd32), .o_RdWen(wen32), .o_AluOp_4(alu32), .o_Class_3(cls32), .o_Word(word32),
        .o_Illegal(ill32), .o_DecCnt_CNTW(cnt32)
    );

    typedef struct packed {
        logic [63:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  alu;
        logic [2:0]  cls;
        logic        word, ill, has_imm, has_alu;
    } bundle_t;

    int unsigned n_checks = 0, n_pass = 0;
    logic        exp_valid;
    int unsigned exp_cnt;
    bundle_t     b64, b32;

    logic [6:0] opc_tab [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};
    logic [3:0] alu_tab [8]  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic bundle_t ref_decode(input logic [31:0] w, input bit is64,
                                           input logic [63:0] p, input logic [63:0] a,
                                           input logic [63:0] b);
        bundle_t     r;
        logic [63:0] m = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        longint      si = longint'(signed'(w));
        longint      imm_i = si >>> 20;
        longint      imm_s = ((si >>> 25) <<< 5) | longint'(w[11:7]);
        longint      imm_b = ((si >>> 31) <<< 12) + (longint'(w[7]) << 11) +
                             (longint'(w[30:25]) << 5) + (longint'(w[11:8]) << 1);
        longint      imm_u = (si >>> 12) <<< 12;
        longint      imm_j = ((si >>> 31) <<< 20) + (longint'(w[19:12]) << 12) +
                             (longint'(w[20]) << 11) + (longint'(w[30:21]) << 1);
        logic [2:0]  f3 = w[14:12];
        logic [6:0]  f7 = w[31:25];
        bit          legal = 1'b1;
        longint      imm = 0;
        r = '0;
        r.has_alu = 1'b1;
        case (w[6:0])
            7'h37: begin imm = imm_u; r.alu = 4'd10; r.wen = 1; r.has_imm = 1; end
            7'h17: begin imm = imm_u; r.wen = 1; r.has_imm = 1; end
            7'h6F: begin imm = imm_j; r.cls = 3'd4; r.wen = 1; r.has_imm = 1; end
            7'h67: begin imm = imm_i; r.cls = 3'd5; r.wen = 1; r.has_imm = 1; legal = (f3 == 0); end
            7'h63: begin
                imm = imm_b; r.cls = 3'd3; r.has_imm = 1;
                legal = !(f3 inside {3'd2, 3'd3});
                r.alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
            end
            7'h03: begin
                imm = imm_i; r.cls = 3'd1; r.wen = 1; r.has_imm = 1;
                legal = (f3 != 7) && (is64 || !(f3 inside {3'd3, 3'd6}));
            end
            7'h23: begin imm = imm_s; r.cls = 3'd2; r.has_imm = 1; legal = (f3 < 3) || (f3 == 3 && is64); end
            7'h13: begin
                imm = imm_i; r.wen = 1; r.has_imm = 1; r.alu = alu_tab[f3];
                if (f3 == 1)
                    legal = is64 ? (w[31:26] == 0) : (w[31:25] == 0);
                if (f3 == 5) begin
                    legal = is64 ? (w[31:26] inside {6'h00, 6'h10}) : (w[31:25] inside {7'h00, 7'h20});
                    r.alu = w[30] ? 4'd7 : 4'd6;
                end
            end
            7'h33: begin
                r.wen = 1;
                legal = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
                r.alu = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : alu_tab[f3];
            end
            7'h1B: begin
                imm = imm_i; r.wen = 1; r.has_imm = 1; r.word = 1;
                legal = is64 && ((f3 == 0) || (f3 == 1 && f7 == 0) || (f3 == 5 && f7 inside {7'h00, 7'h20}));
                r.alu = (f3 == 0) ? 4'd0 : (f3 == 1) ? 4'd2 : (f7 == 7'h20 ? 4'd7 : 4'd6);
            end
            7'h3B: begin
                r.wen = 1; r.word = 1;
                legal = is64 && ((f7 == 0 && f3 inside {3'd0, 3'd1, 3'd5}) ||
                                 (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
                r.alu = (f3 == 1) ? 4'd2 : (f3 == 5) ? (f7 == 7'h20 ? 4'd7 : 4'd6)
                                                     : (f7 == 7'h20 ? 4'd1 : 4'd0);
            end
            7'h0F: begin r.cls = 3'd7; r.has_alu = 0; end
            7'h73: begin r.cls = 3'd6; r.has_alu = 0; legal = (w == 32'h73) || (w == 32'h100073); end
            default: legal = 1'b0;
        endcase
        if (w[1:0] != 2'b11) legal = 1'b0;
        if (!legal) begin
            r.cls = 3'd6; r.wen = 0; r.has_imm = 0; r.has_alu = 0;
        end
        r.ill = !legal;
        r.rd  = w[11:7];
        r.wen = r.wen && (w[11:7] != 0);
        r.imm = 64'(imm) & m;
        r.pc  = p & m;
        r.rs1 = (w[19:15] == 0) ? 64'd0 : (a & m);
        r.rs2 = (w[24:20] == 0) ? 64'd0 : (b & m);
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] op, f7;
        logic [4:0] r1, r2;
        int sel = $urandom_range(0, 15);
        if (sel == 0) return $urandom;
        if (sel == 1) return ($urandom_range(0, 1) != 0) ? 32'h0000_0073 : 32'h0010_0073;
        op = opc_tab[$urandom_range(0, 12)];
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return {f7, r2, r1, 3'($urandom), 5'($urandom), op};
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_cnt   = 0;
        b64 = '0; b64.has_imm = 1; b64.has_alu = 1;
        b32 = b64;
    endtask

    task automatic check_state();
        check("valid64", 64'(v64), 64'(exp_valid));
        check("cnt64", 64'(cnt64), 64'(exp_cnt));
        check("pc64", pc64, b64.pc);
        check("rs1_64", rs1_64, b64.rs1);
        check("rs2_64", rs2_64, b64.rs2);
        check("rd64", 64'(rd64), 64'(b64.rd));
        check("wen64", 64'(wen64), 64'(b64.wen));
        check("cls64", 64'(cls64), 64'(b64.cls));
        check("ill64", 64'(ill64), 64'(b64.ill));
        if (b64.has_imm) check("imm64", imm64, b64.imm);
        if (b64.has_alu) check("alu64", 64'(alu64), 64'(b64.alu));
        if (!b64.ill) check("word64", 64'(word64), 64'(b64.word));
        check("valid32", 64'(v32), 64'(exp_valid));
        check("cnt32", 64'(cnt32), 64'(exp_cnt % 16));
        check("pc32", 64'(pc32), b32.pc);
        check("rs1_32", 64'(rs1_32), b32.rs1);
        check("rs2_32", 64'(rs2_32), b32.rs2);
        check("rd32", 64'(rd32), 64'(b32.rd));
        check("wen32", 64'(wen32), 64'(b32.wen));
        check("cls32", 64'(cls32), 64'(b32.cls));
        check("ill32", 64'(ill32), 64'(b32.ill));
        if (b32.has_imm) check("imm32", 64'(imm32), b32.imm);
        if (b32.has_alu) check("alu32", 64'(alu32), 64'(b32.alu));
        if (!b32.ill) check("word32", 64'(word32), 64'(b32.word));
    endtask

    // Called just after a falling edge: drive, check combinational outputs, step model, check state.
    task automatic do_cycle(input logic v, input logic [31:0] w, input logic f, input logic r,
                            input logic [63:0] a, input logic [63:0] b);
        logic acc;
        in_valid = v; inst = w; flush = f; ds_ready = r; d1 = a; d2 = b;
        pc = {$urandom, $urandom};
        #1;
        check("ready64", 64'(rdy64), 64'(!exp_valid || r));
        check("ready32", 64'(rdy32), 64'(!exp_valid || r));
        check("addr1", 64'(a1_64), 64'(w[19:15]));
        check("addr2", 64'(a2_32), 64'(w[24:20]));
        acc = v && (!exp_valid || r) && !f;
        @(posedge clk);
        if (f) begin
            exp_valid = 1'b0;
        end else if (acc) begin
            exp_valid = 1'b1;
            exp_cnt++;
            b64 = ref_decode(w, 1'b1, pc, a, b);
            b32 = ref_decode(w, 1'b0, pc, a, b);
        end else if (r) begin
            exp_valid = 1'b0;
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; ds_ready = 1; inst = 0; pc = 0; d1 = 0; d2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        check("reset_ready", 64'(rdy64), 64'd1);
        rst_n = 1'b1;

        do_cycle(1, 32'hFFF1_0093, 0, 1, 64'h1234, 64'h5678);
        check("addi_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_rd", 64'(rd64), 64'd1);
        check("addi_wen", 64'(wen64), 64'd1);
        check("addi_cnt", 64'(cnt64), 64'd1);

        do_cycle(1, 32'h4020_81B3, 0, 1, 64'h10, 64'h4);
        check("sub_rs1", rs1_64, 64'h10);
        check("sub_rs2", rs2_64, 64'h4);
        check("sub_alu", 64'(alu64), 64'd1);

        do_cycle(1, 32'hFE00_0EE3, 0, 1, 64'h55, 64'h55);
        check("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_cls", 64'(cls64), 64'd3);
        check("beq_rs1", rs1_64, 64'd0);
        check("beq_wen", 64'(wen64), 64'd0);

        do_cycle(1, 32'h0050_0293, 0, 1, 64'h1, 64'h2);
        do_cycle(1, 32'h0070_0313, 0, 0, 64'h3, 64'h4);
        check("bp_hold_rd", 64'(rd64), 64'd5);
        do_cycle(1, 32'h0070_0313, 0, 1, 64'h3, 64'h4);
        check("bp_next_rd", 64'(rd64), 64'd6);
        check("bp_cnt", 64'(cnt64), 64'd5);

        do_cycle(1, 32'h0010_0093, 1, 0, 64'h7, 64'h8);
        check("flush_valid", 64'(v64), 64'd0);
        check("flush_cnt", 64'(cnt64), 64'd5);

        do_cycle(1, 32'h0000_0000, 0, 1, 64'h9, 64'h9);
        check("zero_ill", 64'(ill64), 64'd1);
        check("zero_wen", 64'(wen64), 64'd0);
        do_cycle(1, 32'h0000_303B, 0, 1, 64'h9, 64'h9);
        check("w32_ill", 64'(ill32), 64'd1);

        for (int i = 0; i < 1500; i++)
            do_cycle($urandom_range(0, 9) < 8, rand_inst(), $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom});

        do_cycle(1, 32'h0050_0293, 0, 1, 64'h1, 64'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid64", 64'(v64), 64'd0);
        check("arst_valid32", 64'(v32), 64'd0);
        check("arst_rd", 64'(rd64), 64'd0);
        check("arst_pc", pc64, 64'd0);
        check("arst_wen", 64'(wen64), 64'd0);
        check("arst_cnt", 64'(cnt64), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_state();
        for (int i = 0; i < 50; i++)
            do_cycle($urandom_range(0, 9) < 8, rand_inst(), $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I decode pipeline stage between fetch and execute.
- Accepts one instruction per cycle over a valid/ready handshake and reads the general register file combinationally.
- Produces a registered decoded bundle: operands, sign-extended immediate, ALU op, instruction class, word-op flag and illegal-instruction flag.
- Adds backpressure, flush, XLEN generalisation, illegal detection and a decoded-instruction counter.

Parameters:
XLEN, 64, datapath width; 32 or 64. 64 enables OP-IMM-32/OP-32 (W) instructions and 6-bit shift amounts.
CNT_W, 32, width of the decoded-instruction counter.

Ports:
i_Clk  in  1  clock
i_Rst_n  in  1  asynchronous active-low reset
i_Flush  in  1  kill the held and incoming instruction
i_Valid  in  1  upstream instruction valid
o_Ready  out  1  stage can accept
i_PC_XLEN  in  XLEN  instruction PC
i_Inst_32  in  32  instruction word
o_GRFReadAddr1_5  out  5  combinational, i_Inst_32[19:15]
o_GRFReadAddr2_5  out  5  combinational, i_Inst_32[24:20]
i_GRFReadData1_XLEN  in  XLEN  rs1 data, same cycle
i_GRFReadData2_XLEN  in  XLEN  rs2 data, same cycle
o_Valid  out  1  decoded bundle valid
i_Ready  in  1  downstream accepts
o_PC_XLEN  out  XLEN  registered PC
o_Rs1Data_XLEN / o_Rs2Data_XLEN  out  XLEN  captured operands
o_Imm_XLEN  out  XLEN  sign-extended immediate
o_Rd_5  out  5  destination register
o_RdWen  out  1  writes rd; forced 0 when rd==0
o_AluOp_4  out  4  ALU operation code
o_Class_3  out  3  instruction class code
o_Word  out  1  W-type op (XLEN=64 only)
o_Illegal  out  1  illegal instruction
o_DecCnt_CNTW  out  CNT_W  count of accepted, unflushed instructions

Behaviour:
- Reset: all registered outputs are 0 and o_Valid=0. o_Ready=1 after reset.
- Handshake: o_Ready = ~o_Valid | i_Ready. An accept (i_Valid & o_Ready & ~i_Flush) loads all bundle registers on the next edge and sets o_Valid=1.
- If o_Valid & i_Ready and there is no accept, o_Valid clears.
- While o_Valid & ~i_Ready, all outputs hold stable. Latency is 1 cycle; throughput is 1 instruction per cycle.
- Flush: i_Flush=1 clears o_Valid on the next edge, blocks acceptance that cycle and does not increment the counter. Flush has priority over accept and hold.
- Operands: rs1/rs2 data are sampled at accept. Address 0 forces the captured value to 0, regardless of GRF input.
- Immediates, sign-extended to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- o_AluOp_4: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10 (LUI).
  - Loads, stores, AUIPC, JAL and JALR use ADD.
  - Branches encode their compare: BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU.
- o_Class_3: ALU=0, LOAD=1, STORE=2, BRANCH=3, JAL=4, JALR=5, SYSTEM=6, FENCE=7.
- o_RdWen=1 for ALU, LOAD, JAL and JALR when rd!=0; 0 for all other classes.
- o_Illegal=1 for any of the following:
  - inst[1:0]!=2'b11
  - unknown opcode
  - OP funct7 not 0000000/0100000, or 0100000 with funct3 other than ADD/SRL
  - shift-immediate upper bits not 0 (SRAI: 010000x), or shamt[5]=1 when XLEN=32
  - LOAD funct3=111; funct3 110 or 011 when XLEN=32
  - STORE funct3>011, or 011 when XLEN=32
  - BRANCH funct3 010 or 011
  - JALR funct3!=0
  - SYSTEM other than ECALL (0x00000073) or EBREAK (0x00100073)
  - OP-IMM-32/OP-32 when XLEN=32
- Illegal instructions still flow with o_Valid=1, o_RdWen=0 and o_Class=SYSTEM.
- Counter: increments on each accept, including illegal instructions. It wraps modulo 2^CNT_W and is cleared only by reset.
- Asynchronous reset mid-transfer drops the held bundle immediately.

Test Plan:
- 0xFFF10093 (ADDI x1,x2,-1), i_Ready=1 → next cycle: o_Valid=1, o_Imm all ones, o_Rd=1, o_RdWen=1, AluOp=0, Class=0, o_Illegal=0, o_DecCnt=1.
- 0x402081B3 (SUB x3,x1,x2), GRF data 0x10/0x4 → o_Rs1Data=0x10, o_Rs2Data=0x4, AluOp=1, Class=0.
- 0xFE000EE3 (BEQ x0,x0,-4), GRF data 0x55 → o_Imm=-4, Class=3, AluOp=1, o_RdWen=0, both operands 0.
- Backpressure: two back-to-back valids with i_Ready=0 on the second cycle → o_Ready=0, outputs unchanged, second instruction appears one cycle after i_Ready=1, count=2.
- i_Flush=1 with i_Valid=1 while holding a bundle → o_Valid=0 next cycle and the counter unchanged. 0x00000000 → o_Illegal=1, o_RdWen=0. With XLEN=32, 0x0000303B → o_Illegal=1.
- Reset asserted while o_Valid=1 → o_Valid=0 and all outputs 0 immediately, before the next clock edge.
